vm1_tve_host: RTL
=================

Name: vm1_tve_host

Overview:
- Register-bus initiator for the vm1 timer (TVE) register interface.
- Accepts single-beat commands on a valid/ready port and turns them into the timer's one-cycle write strobes, output-enable read cycles and (optionally) CSR polling.
- Sits between the CPU-side register decode or a sequencer and vm1_timer; it replaces hand-driven strobe sequences.

Parameters:
- DW, 16: data width of the command, response and timer buses.
- RD_WAIT, 1: cycles the selected oe is held before tve_dout is captured (1..4).
- POLL_TO_W, 16: width of the poll read counter; timeout after 2^POLL_TO_W-1 reads.

Ports:
- tvh_clk  in  1  clock; all state updates on rising edge.
- tvh_reset  in  1  asynchronous, active-high reset.
- tvh_ena  in  1  clock enable; low stalls the FSM.
- req_valid  in  1  command valid.
- req_ready  out  1  high only in IDLE with tvh_ena=1.
- req_op  in  2  00 write, 01 read, 10 poll, 11 illegal.
- req_sel  in  2  0 CSR, 1 LIM, 2 CNT, 3 illegal.
- req_data  in  DW  write data.
- req_mask  in  DW  poll match mask.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_data  out  DW  read, captured or write-echo data.
- rsp_err  out  1  illegal command or poll timeout; qualified by rsp_valid.
- tve_din  out  DW  write data to timer.
- tve_dout  in  DW  read data from timer.
- tve_csr_oe, tve_lim_oe, tve_cnt_oe  out  1 each  read enables.
- tve_csr_wr, tve_lim_wr  out  1 each  write strobes.

Behaviour:
- Reset values: all strobes and oe 0, rsp_valid 0, rsp_err 0, rsp_data 0, tve_din 0, FSM in IDLE, req_ready 1 once tvh_ena=1.
- FSM states: IDLE, WR, RD, CAP, RSP, and (with the optional feature) PGAP.
- Accept: a command is taken at a rising edge when req_valid=1 and req_ready=1 (cycle T). All fields are registered at T.
- Write, sel CSR or LIM:
  - WR at T+1: the matching *_wr is high for exactly one cycle; tve_din = data, held from T+1 until the next accepted write.
  - RSP at T+2: rsp_valid=1, rsp_data = written data, rsp_err=0. Back to IDLE.
- Read, any valid sel:
  - RD for RD_WAIT cycles: the matching *_oe is high.
  - tve_dout is captured at the edge ending the last oe cycle.
  - RSP on the next cycle: rsp_valid=1, rsp_data = captured value. Read latency = RD_WAIT+1 cycles after accept.
- Illegal command: op=11, sel=3, or write to CNT.
  - RSP at T+1 with rsp_err=1, rsp_data=0.
  - No strobe or oe is ever asserted.
- Exclusivity: at most one of the five timer strobe/oe outputs is high in any cycle. oe is never high in the same cycle as a wr.
- tvh_ena=0:
  - State, counters and registers hold.
  - All strobe/oe outputs and rsp_valid are forced low that cycle (gated).
  - A pending strobe or pulse is issued on the first enabled cycle; a one-cycle pulse is never duplicated.
- Reset mid-operation: outputs clear asynchronously. The in-flight command is dropped and no response is produced.
- req_ready is low from accept until the RSP cycle completes. Back-to-back commands are spaced by at least 1 IDLE cycle.

Optional Feature:
- Macro: VM1_TVE_HOST_POLL_EN.
- Defined, op=10 with sel=CSR:
  1. Load the poll counter to all ones.
  2. RD/CAP: read CSR per read timing.
  3. If (captured & req_mask) != 0: RSP with the data, err=0.
  4. Otherwise decrement the counter. If it is now 0: RSP with the last data, err=1. Else PGAP for 1 cycle, then repeat the read.
  5. With RD_WAIT=1 the csr_oe period is 3 cycles.
  6. Poll with sel != CSR is illegal.
- Not defined: op=10 is illegal (err at T+1). The PGAP state and poll counter are not synthesised.

Test Plan:
- Write LIM 0x0005, accepted at T -> tve_lim_wr=1 only at T+1, tve_din=0x0005; rsp_valid at T+2, rsp_data=0x0005, err=0.
- Write CSR 0x001C, then read CSR with the model returning 0x009C -> csr_oe high one cycle (RD_WAIT=1); rsp_data=0x009C two cycles after accept.
- Write to CNT, then op=11 -> each gives rsp_err=1 at T+1, rsp_data=0, zero strobe/oe activity.
- Poll (macro on) with mask 0x0080, model sets CSR bit 7 at cycle 20 -> csr_oe every 3 cycles; response carries bit 7 set, err=0. With POLL_TO_W=4 and the bit never set -> exactly 15 csr_oe pulses, then err=1.
- tvh_ena low for 4 cycles at T+1 of a LIM write -> lim_wr appears once, on the first enabled cycle; rsp follows 1 cycle later.
- tvh_reset pulsed during a read oe cycle -> oe drops without a clock edge; no rsp_valid; req_ready=1 on the first edge after release.

Source files
------------

// File: rtl/vm1_tve_host.sv
// vm1_tve_host: turns single-beat valid/ready commands into vm1 timer (TVE) write strobes and read cycles.
// Optional CSR polling (PGAP state and poll counter) is built only when VM1_TVE_HOST_POLL_EN is defined.
//
// state | meaning
// IDLE  | ready for a command
// WR    | one-cycle *_wr strobe with tve_din driven
// RD    | selected *_oe held for RD_WAIT cycles, tve_dout captured on the last
// CAP   | poll: test captured CSR against mask, count down attempts
// PGAP  | poll: one idle cycle between CSR reads
// RSP   | one-cycle response pulse
module vm1_tve_host #(
   parameter int DW        = 16,
   parameter int RD_WAIT   = 1,
   parameter int POLL_TO_W = 16
) (
   input  logic          tvh_clk,
   input  logic          tvh_reset,
   input  logic          tvh_ena,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [1:0]    req_sel,
   input  logic [DW-1:0] req_data,
   input  logic [DW-1:0] req_mask,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic [DW-1:0] tve_din,
   input  logic [DW-1:0] tve_dout,
   output logic          tve_csr_oe,
   output logic          tve_lim_oe,
   output logic          tve_cnt_oe,
   output logic          tve_csr_wr,
   output logic          tve_lim_wr
);

   localparam logic [1:0] OP_WR   = 2'b00;
   localparam logic [1:0] OP_POLL = 2'b10;
   localparam logic [1:0] SEL_CSR = 2'd0;
   localparam logic [1:0] SEL_LIM = 2'd1;
   localparam logic [1:0] SEL_CNT = 2'd2;
   localparam logic [2:0] RD_LOAD = 3'(RD_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_CAP,
      S_RSP
`ifdef VM1_TVE_HOST_POLL_EN
      , S_PGAP
`endif
   } state_t;

   state_t     state, state_nx;
   logic [1:0] sel_q;
   logic [2:0] rd_cnt;
   logic       cmd_bad;

`ifdef VM1_TVE_HOST_POLL_EN
   localparam logic [POLL_TO_W-1:0] POLL_ONE = POLL_TO_W'(1);
   logic                 is_poll;
   logic [DW-1:0]        mask_q;
   logic [POLL_TO_W-1:0] poll_cnt;
   logic                 poll_hit;
   assign poll_hit = (rsp_data & mask_q) != '0;
`else
   localparam int unused_poll_to_w = POLL_TO_W;
   logic unused_mask;
   assign unused_mask = ^req_mask;
`endif

   always_comb begin
      cmd_bad = (req_op == 2'b11) || (req_sel == 2'b11) ||
                (req_op == OP_WR && req_sel == SEL_CNT);
`ifdef VM1_TVE_HOST_POLL_EN
      if (req_op == OP_POLL && req_sel != SEL_CSR) cmd_bad = 1'b1;
`else
      if (req_op == OP_POLL) cmd_bad = 1'b1;
`endif
   end

   always_ff @(posedge tvh_clk or posedge tvh_reset) begin
      if (tvh_reset)    state <= S_IDLE;
      else if (tvh_ena) state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (req_valid) state_nx = cmd_bad ? S_RSP : (req_op == OP_WR ? S_WR : S_RD);
         S_WR:   state_nx = S_RSP;
`ifdef VM1_TVE_HOST_POLL_EN
         S_RD:   if (rd_cnt == 3'd0) state_nx = is_poll ? S_CAP : S_RSP;
         S_CAP:  state_nx = (poll_hit || poll_cnt == POLL_ONE) ? S_RSP : S_PGAP;
         S_PGAP: state_nx = S_RD;
`else
         S_RD:   if (rd_cnt == 3'd0) state_nx = S_RSP;
`endif
         S_RSP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Command fields are latched at accept; tve_din only changes on an accepted write.
   always_ff @(posedge tvh_clk or posedge tvh_reset) begin
      if (tvh_reset) begin
         sel_q    <= '0;
         rd_cnt   <= '0;
         tve_din  <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
`ifdef VM1_TVE_HOST_POLL_EN
         is_poll  <= 1'b0;
         mask_q   <= '0;
         poll_cnt <= '0;
`endif
      end else if (tvh_ena) begin
         case (state)
            S_IDLE: if (req_valid) begin
               sel_q  <= req_sel;
               rd_cnt <= RD_LOAD;
`ifdef VM1_TVE_HOST_POLL_EN
               is_poll  <= (req_op == OP_POLL);
               mask_q   <= req_mask;
               poll_cnt <= '1;
`endif
               if (cmd_bad) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end else if (req_op == OP_WR) begin
                  tve_din <= req_data;
               end
            end
            S_WR: begin
               rsp_data <= tve_din;
               rsp_err  <= 1'b0;
            end
            S_RD: begin
               if (rd_cnt != 3'd0) begin
                  rd_cnt <= rd_cnt - 3'd1;
               end else begin
                  rsp_data <= tve_dout;
                  rsp_err  <= 1'b0;
               end
            end
`ifdef VM1_TVE_HOST_POLL_EN
            S_CAP: if (!poll_hit) begin
               poll_cnt <= poll_cnt - POLL_ONE;
               if (poll_cnt == POLL_ONE) rsp_err <= 1'b1;
            end
            S_PGAP: rd_cnt <= RD_LOAD;
`endif
            default: ;
         endcase
      end
   end

   // All pulses are gated by tvh_ena so a stalled cycle never issues a strobe.
   always_comb begin
      req_ready  = tvh_ena && (state == S_IDLE);
      rsp_valid  = tvh_ena && (state == S_RSP);
      tve_csr_wr = tvh_ena && (state == S_WR) && (sel_q == SEL_CSR);
      tve_lim_wr = tvh_ena && (state == S_WR) && (sel_q == SEL_LIM);
      tve_csr_oe = tvh_ena && (state == S_RD) && (sel_q == SEL_CSR);
      tve_lim_oe = tvh_ena && (state == S_RD) && (sel_q == SEL_LIM);
      tve_cnt_oe = tvh_ena && (state == S_RD) && (sel_q == SEL_CNT);
   end

endmodule
